regfile_mp: RTL

- Parametrised multi-port integer register file for the writeback stage; next generation of the single-write, two-read register file.
- Provides NREAD combinational read ports and NWRITE write ports, with deterministic same-address write priority.
- Adds synchronous reset clearing, a per-register busy scoreboard (allocate at issue, release at writeback, bulk flush) and a full architectural snapshot for difftest.
- x0 is hardwired to zero and is never busy.

---
 rtl/common.sv | 13 +
 rtl/regfile_wsel.sv | 31 +++
 rtl/regfile_mp.sv | 106 ++++++++++
 3 files changed

// File: rtl/common.sv
// Shared types and constants for the integer register file slice.
// Default geometry matches a 64-bit, 32-entry architectural file.
package common;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [XLEN_DEFAULT-1:0]           data_data_t;
  typedef logic [$clog2(NREGS_DEFAULT)-1:0]  creg_addr_t;

  localparam creg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wsel.sv
// Per-address write-select resolver: reports whether any qualified write
// targets addr this cycle and returns the data of the highest-index winner.
module regfile_wsel
  import common::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int AW     = $clog2(NREGS_DEFAULT),
  parameter int NWRITE = 1
) (
  input  logic [NWRITE-1:0]           we,
  input  logic [NWRITE-1:0][AW-1:0]   waddr,
  input  logic [NWRITE-1:0][XLEN-1:0] wdata,
  input  logic [AW-1:0]               addr,
  output logic                        hit,
  output logic [XLEN-1:0]             data
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned, which is what keeps this block free of inferred latches.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j] && (waddr[j] != AW'(REG_ZERO)) && (waddr[j] == addr)) begin
        hit  = 1'b1;
        data = wdata[j];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard and difftest snapshot.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import common::*;
#(
  parameter int  XLEN   = XLEN_DEFAULT,
  parameter int  NREGS  = NREGS_DEFAULT,
  parameter int  NREAD  = 2,
  parameter int  NWRITE = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NWRITE-1:0]           we,
  input  logic [NWRITE-1:0][AW-1:0]   waddr,
  input  logic [NWRITE-1:0][XLEN-1:0] wdata,
  input  logic [NREAD-1:0][AW-1:0]    raddr,
  output logic [NREAD-1:0][XLEN-1:0]  rdata,
  output logic [NREAD-1:0]            rbusy,
  input  logic                        alloc_en,
  input  logic [AW-1:0]               alloc_rd,
  input  logic                        flush,
  output logic [NREGS-1:0]            busy_vec,
  output logic [NREGS-1:0][XLEN-1:0]  snap
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] wr_hit;
  logic             alloc_ok;

  assign alloc_ok = alloc_en && (alloc_rd != AW'(REG_ZERO));

  // x0 never matches a qualified write and always snapshots as zero.
  assign wr_hit[0] = 1'b0;
  assign snap[0]   = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_snap
    logic [XLEN-1:0] hit_data;

    regfile_wsel #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWRITE (NWRITE)
    ) u_wsel (
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .addr  (AW'(r)),
      .hit   (wr_hit[r]),
      .data  (hit_data)
    );

    assign snap[r] = wr_hit[r] ? hit_data : regs[r];
  end

  // NOTE: the array is reset on purpose: the architecture requires every
  // register to read zero after reset, so this must be flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      // snap already holds next-state: array overlaid with this cycle's winners.
      for (int r = 0; r < NREGS; r++) regs[r] <= snap[r];
      for (int r = 0; r < NREGS; r++) begin
        if (flush) begin
          busy[r] <= 1'b0;
        end else if (alloc_ok && (alloc_rd == AW'(r))) begin
          busy[r] <= 1'b1;
        end else if (wr_hit[r]) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NREAD; i++) begin : g_read
`ifdef REGFILE_BYPASS_EN
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;

    regfile_wsel #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWRITE (NWRITE)
    ) u_byp (
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .addr  (raddr[i]),
      .hit   (byp_hit),
      .data  (byp_data)
    );

    assign rdata[i] = byp_hit ? byp_data : regs[raddr[i]];
    assign rbusy[i] = busy[raddr[i]] & ~byp_hit;
`else
    assign rdata[i] = regs[raddr[i]];
    assign rbusy[i] = busy[raddr[i]];
`endif
  end

endmodule
